// File: rtl/rdma_pkg.sv
// Shared types for the RDMA packer front end: header layout and arbiter state encoding.
package rdma_pkg;

    localparam int ADDR_W = 48;
    localparam int OP_W   = 1;
    localparam int CNT_W  = 31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LAST = 2'd2
    } arb_state_e;

    // Field order matches the flattened request ports and the packer input.
    typedef struct packed {
        logic [ADDR_W-1:0] src_address;
        logic [ADDR_W-1:0] dst_address;
        logic [OP_W-1:0]   operation;
        logic [CNT_W-1:0]  counter;
    } rdma_hdr_t;

endpackage

// File: rtl/rr_select.sv
// Combinational rotating-priority selector: first asserted request at or after ptr wins.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/rdma_packer_arbiter.sv
// Round-robin scheduler sharing one rdma_packer between NUM_REQ header requesters,
// optionally holding one packet in flight until the packer's last output beat.
module rdma_packer_arbiter
    import rdma_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int WAIT_FOR_LAST = 1,
    parameter int TIMEOUT       = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_src_address,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dst_address,
    input  logic [NUM_REQ*OP_W-1:0]   req_operation,
    input  logic [NUM_REQ*CNT_W-1:0]  req_counter,
    output logic                      pk_valid,
    input  logic                      pk_ready,
    output logic [ADDR_W-1:0]         pk_src_address,
    output logic [ADDR_W-1:0]         pk_dst_address,
    output logic [OP_W-1:0]           pk_operation,
    output logic [CNT_W-1:0]          pk_counter,
    input  logic                      pk_last_beat,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, grant_id_q, win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic            win_any;
    logic [WD_W-1:0] wdog_q;
    rdma_hdr_t       hdr_all [NUM_REQ];
    rdma_hdr_t       hdr_win, hdr_q;
    logic            accept, handshake;

    rr_select #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr_select (
        .req  (req_valid),
        .ptr  (ptr_q),
        .grant(win_onehot),
        .idx  (win_idx),
        .any  (win_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hdr_all[i].src_address = req_src_address[i*ADDR_W +: ADDR_W];
            hdr_all[i].dst_address = req_dst_address[i*ADDR_W +: ADDR_W];
            hdr_all[i].operation   = req_operation[i*OP_W +: OP_W];
            hdr_all[i].counter     = req_counter[i*CNT_W +: CNT_W];
        end
    end

    assign hdr_win   = hdr_all[win_idx];
    assign accept    = (state_q == IDLE) && win_any && !rst;
    assign handshake = (state_q == ISSUE) && pk_ready;

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        pk_valid    = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    req_ready = win_onehot;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                pk_valid = 1'b1;
                if (pk_ready) state_d = (WAIT_FOR_LAST != 0) ? WAIT_LAST : IDLE;
            end
            WAIT_LAST: begin
                // A last beat arriving on the expiry cycle still counts as a normal completion.
                if (pk_last_beat) begin
                    state_d = IDLE;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) req_ready = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            hdr_q      <= '0;
            wdog_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (accept) begin
                hdr_q      <= hdr_win;
                grant_id_q <= win_idx;
            end
            if (handshake) begin
                ptr_q <= (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            end
            if (state_q == WAIT_LAST && state_d == WAIT_LAST) wdog_q <= wdog_q + 1'b1;
            else                                              wdog_q <= '0;
        end
    end

    assign pk_src_address = hdr_q.src_address;
    assign pk_dst_address = hdr_q.dst_address;
    assign pk_operation   = hdr_q.operation;
    assign pk_counter     = hdr_q.counter;
    assign grant_id       = grant_id_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_rdma_packer_arbiter.sv
// Directed bench: one instance waits for the last beat (TIMEOUT=8), one issues back-to-back.
module tb_rdma_packer_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N*48-1:0] req_src_address, req_dst_address;
    logic [N-1:0]    req_operation;
    logic [N*31-1:0] req_counter;
    logic            pk_ready, pk_last_beat;

    logic [47:0] src_v [N];
    logic [47:0] dst_v [N];
    logic        op_v  [N];
    logic [30:0] cnt_v [N];

    logic [N-1:0] w_req_ready, b_req_ready;
    logic         w_pk_valid, b_pk_valid;
    logic [47:0]  w_pk_src, b_pk_src, w_pk_dst, b_pk_dst;
    logic         w_pk_op, b_pk_op;
    logic [30:0]  w_pk_cnt, b_pk_cnt;
    logic [1:0]   w_grant_id, b_grant_id;
    logic         w_busy, b_busy, w_timeout_err, b_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_src_address[48*i +: 48] = src_v[i];
            req_dst_address[48*i +: 48] = dst_v[i];
            req_operation[i]            = op_v[i];
            req_counter[31*i +: 31]     = cnt_v[i];
        end
    end

    rdma_packer_arbiter #(.NUM_REQ(N), .ID_W(2), .WAIT_FOR_LAST(1), .TIMEOUT(8)) dut_w (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(w_req_ready),
        .req_src_address(req_src_address), .req_dst_address(req_dst_address),
        .req_operation(req_operation), .req_counter(req_counter),
        .pk_valid(w_pk_valid), .pk_ready(pk_ready),
        .pk_src_address(w_pk_src), .pk_dst_address(w_pk_dst),
        .pk_operation(w_pk_op), .pk_counter(w_pk_cnt),
        .pk_last_beat(pk_last_beat), .grant_id(w_grant_id),
        .busy(w_busy), .timeout_err(w_timeout_err)
    );

    rdma_packer_arbiter #(.NUM_REQ(N), .ID_W(2), .WAIT_FOR_LAST(0), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_req_ready),
        .req_src_address(req_src_address), .req_dst_address(req_dst_address),
        .req_operation(req_operation), .req_counter(req_counter),
        .pk_valid(b_pk_valid), .pk_ready(pk_ready),
        .pk_src_address(b_pk_src), .pk_dst_address(b_pk_dst),
        .pk_operation(b_pk_op), .pk_counter(b_pk_cnt),
        .pk_last_beat(pk_last_beat), .grant_id(b_grant_id),
        .busy(b_busy), .timeout_err(b_timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; pk_ready = 1'b0; pk_last_beat = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; pk_ready = 1'b0; pk_last_beat = 1'b0;
        step();
        n_checks++; if (w_pk_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pk_valid: got %b expected 0", w_pk_valid); end
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", w_busy); end
        n_checks++; if (w_req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", w_req_ready); end
        n_checks++; if (w_grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d expected 0", w_grant_id); end
        n_checks++; if (w_timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b expected 0", w_timeout_err); end
        n_checks++; if (w_pk_src !== 48'h0 || w_pk_cnt !== 31'h0) begin n_fail++; $display("FAIL rst_pk_fields: got %h/%h expected 0/0", w_pk_src, w_pk_cnt); end
        n_checks++; if (b_pk_valid !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL rst_b_state: got %b%b expected 00", b_pk_valid, b_busy); end
        // Move the pointer to 2, then reset while the next grant sits in ISSUE.
        rst = 1'b0; req_valid = 4'b0010; #1;
        n_checks++; if (w_req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 0010", w_req_ready); end
        step(); req_valid = '0; pk_ready = 1'b1; #1;
        step(); pk_ready = 1'b0; pk_last_beat = 1'b1; #1;
        step(); pk_last_beat = 1'b0; req_valid = 4'hF; #1;
        n_checks++; if (w_req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_ptr_adv: got %b expected 0100", w_req_ready); end
        step();
        n_checks++; if (w_pk_valid !== 1'b1 || w_grant_id !== 2'd2) begin n_fail++; $display("FAIL rst_pre_issue: got v=%b id=%0d expected v=1 id=2", w_pk_valid, w_grant_id); end
        #1 rst = 1'b1; #1;
        n_checks++; if (w_pk_valid !== 1'b0 || w_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_issue: got v=%b busy=%b expected 0 0", w_pk_valid, w_busy); end
        n_checks++; if (w_req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0000", w_req_ready); end
        step(); rst = 1'b0; #1;
        n_checks++; if (w_req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_cleared: got %b expected 0001", w_req_ready); end
        step();
        n_checks++; if (w_grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_regrant_id: got %0d expected 0", w_grant_id); end
    endtask

    task automatic test_single_req2();
        do_reset();
        req_valid = 4'b0100; #1;
        n_checks++; if (w_req_ready !== 4'b0100 || b_req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b/%b expected 0100", w_req_ready, b_req_ready); end
        n_checks++; if (w_pk_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_early_valid: got %b expected 0", w_pk_valid); end
        step();
        // Fields change after the accept cycle; the registered header must not follow.
        req_valid = '0; src_v[2] = 48'h0; dst_v[2] = 48'h0; op_v[2] = 1'b1; cnt_v[2] = 31'h0; #1;
        n_checks++; if (w_pk_valid !== 1'b1 || b_pk_valid !== 1'b1) begin n_fail++; $display("FAIL single_pk_valid: got %b/%b expected 1", w_pk_valid, b_pk_valid); end
        n_checks++; if (w_pk_src !== 48'hd82c07cc53ed) begin n_fail++; $display("FAIL single_src: got %h expected d82c07cc53ed", w_pk_src); end
        n_checks++; if (w_pk_dst !== 48'hc2094cbc7ce0) begin n_fail++; $display("FAIL single_dst: got %h expected c2094cbc7ce0", w_pk_dst); end
        n_checks++; if (w_pk_op !== 1'b0) begin n_fail++; $display("FAIL single_op: got %b expected 0", w_pk_op); end
        n_checks++; if (w_pk_cnt !== 31'h21242f1f) begin n_fail++; $display("FAIL single_cnt: got %h expected 21242f1f", w_pk_cnt); end
        n_checks++; if (w_grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant_id: got %0d expected 2", w_grant_id); end
        src_v[2] = 48'hd82c07cc53ed; dst_v[2] = 48'hc2094cbc7ce0; op_v[2] = 1'b0; cnt_v[2] = 31'h21242f1f;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'hF; pk_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_checks++; if (b_req_ready !== 4'(1 << (g % 4)) || b_pk_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept[%0d]: got rdy=%b v=%b expected rdy=%b v=0", g, b_req_ready, b_pk_valid, 4'(1 << (g % 4))); end
            step(); #1;
            n_checks++; if (b_pk_valid !== 1'b1 || b_grant_id !== 2'(g % 4) || b_pk_src !== src_v[g % 4]) begin n_fail++; $display("FAIL b2b_issue[%0d]: got v=%b id=%0d src=%h expected v=1 id=%0d src=%h", g, b_pk_valid, b_grant_id, b_pk_src, g % 4, src_v[g % 4]); end
            step();
        end
    endtask

    task automatic test_wait_last();
        do_reset();
        req_valid = 4'hF;
        for (int p = 0; p < 4; p++) begin
            pk_ready = 1'b0; pk_last_beat = 1'b0; #1;
            n_checks++; if (w_req_ready !== 4'(1 << p)) begin n_fail++; $display("FAIL wl_grant[%0d]: got %b expected %b", p, w_req_ready, 4'(1 << p)); end
            step();
            pk_last_beat = 1'b1;
            for (int c = 0; c < 16; c++) begin
                pk_ready = (c == 15) ? 1'b1 : 1'($urandom_range(0, 1)); #1;
                n_checks++; if (w_pk_valid !== 1'b1 || w_pk_src !== src_v[p] || w_pk_cnt !== cnt_v[p] || w_grant_id !== 2'(p)) begin n_fail++; $display("FAIL wl_hold[%0d]: got v=%b src=%h cnt=%h id=%0d expected v=1 src=%h cnt=%h id=%0d", p, w_pk_valid, w_pk_src, w_pk_cnt, w_grant_id, src_v[p], cnt_v[p], p); end
                step();
                if (pk_ready) break;
            end
            pk_ready = 1'b0; pk_last_beat = 1'b0;
            for (int b = 0; b < 2; b++) begin
                #1;
                n_checks++; if (w_busy !== 1'b1 || w_pk_valid !== 1'b0 || w_req_ready !== 4'b0000) begin n_fail++; $display("FAIL wl_wait[%0d]: got busy=%b v=%b rdy=%b expected 1 0 0000", p, w_busy, w_pk_valid, w_req_ready); end
                step();
            end
            pk_last_beat = 1'b1; #1;
            n_checks++; if (w_req_ready !== 4'b0000) begin n_fail++; $display("FAIL wl_last_cycle[%0d]: got %b expected 0000", p, w_req_ready); end
            step();
        end
        pk_last_beat = 1'b0; #1;
        n_checks++; if (w_req_ready !== 4'b0001) begin n_fail++; $display("FAIL wl_wrap: got %b expected 0001", w_req_ready); end
    endtask

    task automatic test_timeout();
        do_reset();
        req_valid = 4'b0001; #1;
        n_checks++; if (w_req_ready !== 4'b0001) begin n_fail++; $display("FAIL to_grant: got %b expected 0001", w_req_ready); end
        step(); req_valid = '0; pk_ready = 1'b1; #1;
        step(); pk_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_checks++; if (w_timeout_err !== (k == 8) || w_busy !== 1'b1) begin n_fail++; $display("FAIL to_wait[%0d]: got err=%b busy=%b expected err=%b busy=1", k, w_timeout_err, w_busy, (k == 8)); end
            step();
        end
        #1;
        n_checks++; if (w_busy !== 1'b0 || w_timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_idle: got busy=%b err=%b expected 0 0", w_busy, w_timeout_err); end
        req_valid = 4'b0010; #1;
        n_checks++; if (w_req_ready !== 4'b0010) begin n_fail++; $display("FAIL to_next_grant: got %b expected 0010", w_req_ready); end
        step(); req_valid = '0; #1;
        n_checks++; if (w_pk_valid !== 1'b1 || w_grant_id !== 2'd1) begin n_fail++; $display("FAIL to_next_issue: got v=%b id=%0d expected 1 1", w_pk_valid, w_grant_id); end
    endtask

    task automatic test_last_vs_expiry();
        do_reset();
        req_valid = 4'b0100; #1;
        step(); req_valid = '0; pk_ready = 1'b1; #1;
        step(); pk_ready = 1'b0; pk_last_beat = 1'b1; #1;
        step(); pk_last_beat = 1'b0;
        req_valid = 4'b1000; #1;
        n_checks++; if (w_req_ready !== 4'b1000) begin n_fail++; $display("FAIL lx_req3: got %b expected 1000", w_req_ready); end
        step(); req_valid = '0; pk_ready = 1'b1; #1;
        step(); pk_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            n_checks++; if (w_timeout_err !== 1'b0) begin n_fail++; $display("FAIL lx_early_err[%0d]: got %b expected 0", k, w_timeout_err); end
            step();
        end
        pk_last_beat = 1'b1; #1;
        n_checks++; if (w_timeout_err !== 1'b0) begin n_fail++; $display("FAIL lx_coincide_err: got %b expected 0", w_timeout_err); end
        step(); pk_last_beat = 1'b0; #1;
        n_checks++; if (w_busy !== 1'b0 || w_timeout_err !== 1'b0) begin n_fail++; $display("FAIL lx_idle: got busy=%b err=%b expected 0 0", w_busy, w_timeout_err); end
        req_valid = 4'hF; #1;
        n_checks++; if (w_req_ready !== 4'b0001) begin n_fail++; $display("FAIL lx_ptr_wrap: got %b expected 0001", w_req_ready); end
        step(); req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_v[i] = 48'h1000_0000_0000 + 48'(i * 48'h0101_0101);
            dst_v[i] = 48'h2000_0000_0000 + 48'(i * 48'h0202_0202);
            op_v[i]  = 1'(i % 2);
            cnt_v[i] = 31'h0100_0000 + 31'(i * 31'h11);
        end
        src_v[2] = 48'hd82c07cc53ed; dst_v[2] = 48'hc2094cbc7ce0; op_v[2] = 1'b0; cnt_v[2] = 31'h21242f1f;

        test_reset();
        test_single_req2();
        test_back_to_back();
        test_wait_last();
        test_timeout();
        test_last_vs_expiry();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
